sssp_pp_gen: RTL and testbench

- Parametrised next-generation SSSP processing pipeline for one partition lane.
- Scatter path: turns (edge, active source attribute) into distance updates, with saturating arithmetic and a configurable latency.
- Gather path: min-reduces updates into the partition URAM. Full read-after-write forwarding covers the whole pipeline plus the URAM read latency.
- Adds a sticky partition-active flag, a committed-write counter and a busy indicator for the partition scheduler.

---
 rtl/sssp_pp_gen.sv | 181 ++++++++++++++++++
 tb/tb_sssp_pp_gen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sssp_pp_gen.sv
// sssp_pp_gen: one SSSP partition lane -- saturating scatter pipe and min-reducing gather pipe
// with read-after-write forwarding, plus partition activity/commit bookkeeping.
`default_nettype none

module sssp_pp_gen #(
  parameter int PIPE_DEPTH  = 3,
  parameter int RD_LAT      = 2,
  parameter int URAM_DATA_W = 32,
  parameter int PAR_SIZE_W  = 18,
  parameter int WEIGHT_W    = 16,
  parameter int DEST_W      = 24,
  parameter int EDGE_W      = 64,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [EDGE_W-1:0]      edge_word,
  input  logic                   edge_valid,
  input  logic [URAM_DATA_W-1:0] src_attr,
  input  logic                   src_attr_valid,
  input  logic [63:0]            upd_word,
  input  logic                   upd_valid,
  input  logic [URAM_DATA_W-1:0] dest_attr,
  input  logic                   dest_attr_valid,
  output logic [URAM_DATA_W-1:0] wr_data,
  output logic [PAR_SIZE_W-1:0]  wr_addr,
  output logic                   wr_valid,
  output logic [63:0]            out_word,
  output logic                   out_valid,
  output logic                   par_active,
  output logic [CNT_W-1:0]       wr_cnt,
  output logic                   busy
);

  localparam int DW = URAM_DATA_W - 1;
  localparam int HN = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam logic [URAM_DATA_W-1:0] INF = {1'b0, {DW{1'b1}}};

  localparam logic [1:0] MODE_SCATTER = 2'd1;
  localparam logic [1:0] MODE_GATHER  = 2'd2;
  localparam logic [1:0] MODE_CLEAR   = 2'd3;

  // ---------------- scatter ----------------
  logic [WEIGHT_W-1:0]    sc_weight;
  logic [DEST_W-1:0]      sc_dest;
  logic [URAM_DATA_W-1:0] sc_sum;
  logic                   sc_acc;

  logic [PIPE_DEPTH-1:0]  sc_occ_q;
  logic [PIPE_DEPTH-1:0]  sc_vld_q;
  logic [63:0]            sc_word_q [PIPE_DEPTH];

  assign sc_weight = edge_word[EDGE_W-1 -: WEIGHT_W];
  assign sc_dest   = edge_word[EDGE_W-WEIGHT_W-1 -: DEST_W];
  assign sc_sum    = URAM_DATA_W'(sc_weight) + {1'b0, src_attr[DW-1:0]};
  assign sc_acc    = (mode == MODE_SCATTER) && edge_valid && src_attr_valid
                     && src_attr[URAM_DATA_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_occ_q <= '0;
      sc_vld_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) sc_word_q[i] <= '0;
    end else begin
      // Saturated sums still occupy their slot so busy reflects them.
      sc_occ_q <= {sc_occ_q[PIPE_DEPTH-2:0], sc_acc};
      sc_vld_q <= {sc_vld_q[PIPE_DEPTH-2:0], sc_acc && (sc_sum < INF)};
      if (sc_acc) sc_word_q[0] <= {32'(sc_sum[DW-1:0]), 32'(sc_dest)};
      for (int i = 1; i < PIPE_DEPTH; i++) sc_word_q[i] <= sc_word_q[i-1];
    end
  end

  assign out_valid = sc_vld_q[PIPE_DEPTH-1];
  assign out_word  = sc_word_q[PIPE_DEPTH-1];

  // ---------------- gather ----------------
  logic                  g_acc;
  logic                  g_wr;
  logic [PAR_SIZE_W-1:0] g_addr;
  logic [DW-1:0]         g_val;
  logic [DW-1:0]         g_old;

  logic [PIPE_DEPTH-1:0] g_occ_q;
  logic [PIPE_DEPTH-1:0] g_wv_q;
  logic [PAR_SIZE_W-1:0] g_addr_q [PIPE_DEPTH];
  logic [DW-1:0]         g_val_q  [PIPE_DEPTH];

  logic [HN-1:0]         h_wv_q;
  logic [PAR_SIZE_W-1:0] h_addr_q [HN];
  logic [DW-1:0]         h_val_q  [HN];

  assign g_acc  = (mode == MODE_GATHER) && upd_valid && dest_attr_valid;
  assign g_addr = upd_word[PAR_SIZE_W-1:0];
  assign g_val  = upd_word[32 +: DW];

  // Scan oldest to youngest so the youngest matching write is left in g_old.
  always_comb begin
    g_old = dest_attr[DW-1:0];
    for (int i = HN - 1; i >= 0; i--) begin
      if (h_wv_q[i] && (h_addr_q[i] == g_addr)) g_old = h_val_q[i];
    end
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      if (g_wv_q[i] && (g_addr_q[i] == g_addr)) g_old = g_val_q[i];
    end
  end

  assign g_wr = g_acc && (g_val < g_old);

  always_ff @(posedge clk) begin
    if (rst) begin
      g_occ_q <= '0;
      g_wv_q  <= '0;
      h_wv_q  <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        g_addr_q[i] <= '0;
        g_val_q[i]  <= '0;
      end
      for (int i = 0; i < HN; i++) begin
        h_addr_q[i] <= '0;
        h_val_q[i]  <= '0;
      end
    end else begin
      g_occ_q <= {g_occ_q[PIPE_DEPTH-2:0], g_acc};
      g_wv_q  <= {g_wv_q[PIPE_DEPTH-2:0], g_wr};
      if (g_acc) begin
        g_addr_q[0] <= g_addr;
        g_val_q[0]  <= g_val;
      end
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        g_addr_q[i] <= g_addr_q[i-1];
        g_val_q[i]  <= g_val_q[i-1];
      end
      // History of emitted writes; empty when the read latency is a single cycle.
      h_wv_q[0]   <= (RD_LAT > 1) && g_wv_q[PIPE_DEPTH-1];
      h_addr_q[0] <= g_addr_q[PIPE_DEPTH-1];
      h_val_q[0]  <= g_val_q[PIPE_DEPTH-1];
      for (int i = 1; i < HN; i++) begin
        h_wv_q[i]   <= h_wv_q[i-1];
        h_addr_q[i] <= h_addr_q[i-1];
        h_val_q[i]  <= h_val_q[i-1];
      end
    end
  end

  assign wr_valid = g_wv_q[PIPE_DEPTH-1];
  assign wr_addr  = g_addr_q[PIPE_DEPTH-1];
  assign wr_data  = {g_wv_q[PIPE_DEPTH-1], g_val_q[PIPE_DEPTH-1]};

  // ---------------- bookkeeping ----------------
  logic       commit;
  logic       par_active_q;
  logic [CNT_W-1:0] wr_cnt_q;

  // A write is committed on the edge that presents it on wr_*; it beats a concurrent clear.
  assign commit = g_wv_q[PIPE_DEPTH-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      par_active_q <= 1'b0;
      wr_cnt_q     <= '0;
    end else if (mode == MODE_CLEAR) begin
      par_active_q <= commit;
      wr_cnt_q     <= commit ? CNT_W'(1) : '0;
    end else if (commit) begin
      par_active_q <= 1'b1;
      wr_cnt_q     <= wr_cnt_q + CNT_W'(1);
    end
  end

  assign par_active = par_active_q;
  assign wr_cnt     = wr_cnt_q;
  assign busy       = |{sc_occ_q, g_occ_q};

  logic unused_bits;
  assign unused_bits = ^{edge_word[EDGE_W-WEIGHT_W-DEST_W-1:0], upd_word[31:PAR_SIZE_W],
                         upd_word[63:32+DW], dest_attr[URAM_DATA_W-1]};

endmodule

`default_nettype wire

// File: tb/tb_sssp_pp_gen.sv
// tb_sssp_pp_gen: directed literal checks plus randomized traffic against a
// cycle-indexed behavioural model of sssp_pp_gen.
`default_nettype none

module tb_sssp_pp_gen;
  localparam int D  = 3;
  localparam int RL = 2;
  localparam int PW = 18;
  localparam int DW = 31;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode;
  logic [63:0] edge_word;
  logic        edge_valid;
  logic [31:0] src_attr;
  logic        src_attr_valid;
  logic [63:0] upd_word;
  logic        upd_valid;
  logic [31:0] dest_attr;
  logic        dest_attr_valid;
  logic [31:0] wr_data;
  logic [17:0] wr_addr;
  logic        wr_valid;
  logic [63:0] out_word;
  logic        out_valid;
  logic        par_active;
  logic [31:0] wr_cnt;
  logic        busy;

  always #5 clk = ~clk;

  sssp_pp_gen #(.PIPE_DEPTH(D), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .edge_word(edge_word), .edge_valid(edge_valid),
    .src_attr(src_attr), .src_attr_valid(src_attr_valid),
    .upd_word(upd_word), .upd_valid(upd_valid),
    .dest_attr(dest_attr), .dest_attr_valid(dest_attr_valid),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid),
    .out_word(out_word), .out_valid(out_valid),
    .par_active(par_active), .wr_cnt(wr_cnt), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time is counted in posedges; an accept sampled at posedge n shows its result
  // in the cycle following posedge n+D-1.
  typedef struct { int m; logic [PW-1:0] a; logic [DW-1:0] v; } wr_t;
  wr_t                 wlist[$];
  logic [63:0]         e_out [int];
  logic [PW+DW-1:0]    e_wr  [int];
  int                  cyc = 0;
  int                  busy_end = -1;
  logic [31:0]         m_cnt = 0;
  logic                m_act = 0;
  logic                e_ov, e_wv, e_busy;
  logic [63:0]         e_ow;
  logic [PW-1:0]       e_wa;
  logic [DW-1:0]       e_wd;
  bit                  model_live = 0;

  always @(posedge clk) begin
    logic             commit;
    longint           s;
    logic [PW-1:0]    a;
    logic [DW-1:0]    v, old;
    logic [PW+DW-1:0] tw;
    int               best;
    wr_t              w;
    cyc++;
    if (rst) begin
      wlist.delete(); e_out.delete(); e_wr.delete();
      busy_end = -1; m_cnt = 0; m_act = 0;
    end else begin
      commit = e_wr.exists(cyc);
      if (mode == 2'd3) begin
        m_act = commit;
        m_cnt = commit ? 32'd1 : 32'd0;
      end else if (commit) begin
        m_act = 1'b1;
        m_cnt = m_cnt + 32'd1;
      end
      if (mode == 2'd1 && edge_valid && src_attr_valid && src_attr[31]) begin
        busy_end = cyc + D - 1;
        s = longint'(edge_word[63:48]) + longint'(src_attr[30:0]);
        if (s < 64'h7FFF_FFFF) e_out[cyc+D-1] = {32'(s), 8'h0, edge_word[47:24]};
      end
      if (mode == 2'd2 && upd_valid && dest_attr_valid) begin
        busy_end = cyc + D - 1;
        a = upd_word[PW-1:0];
        v = upd_word[62:32];
        old = dest_attr[30:0];
        best = -1000;
        foreach (wlist[i])
          if (wlist[i].a == a && wlist[i].m >= cyc - D - RL + 1 && wlist[i].m > best) begin
            best = wlist[i].m;
            old  = wlist[i].v;
          end
        if (v < old) begin
          e_wr[cyc+D-1] = {a, v};
          w.m = cyc; w.a = a; w.v = v;
          wlist.push_back(w);
        end
      end
      while (wlist.size() > 0 && wlist[0].m < cyc - D - RL) void'(wlist.pop_front());
    end
    e_ov = e_out.exists(cyc);
    e_ow = e_ov ? e_out[cyc] : 64'h0;
    e_wv = e_wr.exists(cyc);
    tw   = e_wv ? e_wr[cyc] : '0;
    e_wa = tw[PW+DW-1:DW];
    e_wd = tw[DW-1:0];
    e_busy = (cyc <= busy_end);
    if (e_ov) e_out.delete(cyc);
    if (e_wv) e_wr.delete(cyc);
    model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      if (e_ov) chk("out_word", out_word, e_ow);
      chk("wr_valid", 64'(wr_valid), 64'(e_wv));
      if (e_wv) begin
        chk("wr_addr", 64'(wr_addr), 64'(e_wa));
        chk("wr_data", 64'(wr_data), 64'({1'b1, e_wd}));
      end
      chk("par_active", 64'(par_active), 64'(m_act));
      chk("wr_cnt", 64'(wr_cnt), 64'(m_cnt));
      chk("busy", 64'(busy), 64'(e_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    mode = 2'd0; edge_word = '0; edge_valid = 1'b0; src_attr = '0; src_attr_valid = 1'b0;
    upd_word = '0; upd_valid = 1'b0; dest_attr = '0; dest_attr_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edge_in(input logic [15:0] w, input logic [23:0] d, input logic [31:0] sa);
    mode = 2'd1; edge_word = {w, d, 24'h0}; edge_valid = 1'b1;
    src_attr = sa; src_attr_valid = 1'b1;
    step(1);
    idle_inputs();
  endtask

  task automatic upd_in(input logic [31:0] v, input logic [31:0] a, input logic [31:0] da);
    mode = 2'd2; upd_word = {v, a}; upd_valid = 1'b1;
    dest_attr = da; dest_attr_valid = 1'b1;
    step(1);
    idle_inputs();
  endtask

  initial begin
    int r;
    idle_inputs();
    rst = 1'b1;
    step(3);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_wr_valid", 64'(wr_valid), 0);
    chk("rst_wr_data", 64'(wr_data), 0);
    chk("rst_wr_cnt", 64'(wr_cnt), 0);
    chk("rst_busy", 64'(busy), 0);
    rst = 1'b0;
    step(1);

    // scatter: 5 + 100 to dest 0x42
    edge_in(16'd5, 24'h42, {1'b1, 31'd100});
    step(1);
    chk("scat_early", 64'(out_valid), 0);
    step(1);
    chk("scat_valid", 64'(out_valid), 1);
    chk("scat_word", out_word, {32'd105, 32'h42});
    edge_in(16'd5, 24'h42, {1'b0, 31'd100});
    chk("scat_inactive_busy", 64'(busy), 0);
    step(2);
    chk("scat_inactive", 64'(out_valid), 0);

    // saturation
    edge_in(16'hFFFF, 24'h42, {1'b1, 31'h7FFF_FFEF});
    chk("sat_busy1", 64'(busy), 1);
    step(1);
    chk("sat_busy2", 64'(busy), 1);
    step(1);
    chk("sat_busy3", 64'(busy), 1);
    chk("sat_drop", 64'(out_valid), 0);
    step(1);
    chk("sat_idle", 64'(busy), 0);

    // gather basic
    upd_in(32'd30, 32'd7, {1'b0, 31'd50});
    step(2);
    chk("g_wr_valid", 64'(wr_valid), 1);
    chk("g_wr_addr", 64'(wr_addr), 7);
    chk("g_wr_data", 64'(wr_data), 64'h8000_001E);
    chk("g_wr_cnt", 64'(wr_cnt), 1);
    chk("g_par_active", 64'(par_active), 1);
    upd_in(32'd60, 32'd7, {1'b0, 31'd50});
    step(2);
    chk("g_nowrite", 64'(wr_valid), 0);
    chk("g_cnt_hold", 64'(wr_cnt), 1);
    mode = 2'd3;
    step(1);
    mode = 2'd0;
    chk("clr_cnt", 64'(wr_cnt), 0);
    chk("clr_act", 64'(par_active), 0);

    // back-to-back hazard on address 9
    upd_in(32'd40, 32'd9, 32'd100);
    upd_in(32'd20, 32'd9, 32'd100);
    upd_in(32'd35, 32'd9, 32'd100);
    chk("haz_w40", 64'(wr_data), 64'h8000_0028);
    step(1);
    chk("haz_w20_v", 64'(wr_valid), 1);
    chk("haz_w20", 64'(wr_data), 64'h8000_0014);
    step(1);
    chk("haz_w35_none", 64'(wr_valid), 0);
    chk("haz_cnt", 64'(wr_cnt), 2);

    // post-emit forwarding window
    upd_in(32'd20, 32'd3, 32'd100);
    step(2);
    chk("win_emit", 64'(wr_valid), 1);
    chk("win_addr", 64'(wr_addr), 3);
    step(1);
    upd_in(32'd25, 32'd3, 32'd100);
    step(1);
    upd_in(32'd25, 32'd3, 32'd100);
    chk("win_inside", 64'(wr_valid), 0);
    step(2);
    chk("win_outside", 64'(wr_valid), 1);
    chk("win_data", 64'(wr_data), 64'h8000_0019);
    chk("win_cnt", 64'(wr_cnt), 4);

    // clear colliding with a commit
    upd_in(32'd5, 32'd12, 32'd100);
    step(1);
    mode = 2'd3;
    step(1);
    chk("clrw_valid", 64'(wr_valid), 1);
    chk("clrw_cnt", 64'(wr_cnt), 1);
    chk("clrw_act", 64'(par_active), 1);
    step(1);
    mode = 2'd0;
    chk("clr2_cnt", 64'(wr_cnt), 0);
    chk("clr2_act", 64'(par_active), 0);

    // reset with work in flight
    upd_in(32'd5, 32'd11, 32'd100);
    upd_in(32'd4, 32'd11, 32'd100);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rstf_busy", 64'(busy), 0);
    chk("rstf_wr0", 64'(wr_valid), 0);
    step(1);
    chk("rstf_wr1", 64'(wr_valid), 0);
    step(1);
    chk("rstf_wr2", 64'(wr_valid), 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 199));
      rst = (r == 0);
      mode = (r < 90) ? 2'd2 : (r < 160) ? 2'd1 : (r < 175) ? 2'd3 : 2'd0;
      edge_valid = ($urandom_range(0, 3) != 0);
      src_attr_valid = ($urandom_range(0, 3) != 0);
      edge_word = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) edge_word[63:48] = 16'($urandom_range(0, 50));
      src_attr[31] = ($urandom_range(0, 3) != 0);
      src_attr[30:0] = ($urandom_range(0, 5) == 0)
                       ? 31'h7FFF_FFFF - 31'($urandom_range(0, 131072))
                       : 31'($urandom_range(0, 1000));
      upd_valid = ($urandom_range(0, 3) != 0);
      dest_attr_valid = ($urandom_range(0, 3) != 0);
      upd_word = {1'($urandom), 31'($urandom_range(0, 200)), 14'($urandom),
                  18'($urandom_range(0, 3))};
      dest_attr = {1'($urandom), 31'($urandom_range(0, 200))};
      step(1);
    end
    rst = 1'b0;
    idle_inputs();
    step(D + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
